// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Desc     : VGA raster timing: DrawX/DrawY counters, hs/vs/blank decode,
//            line/frame start pulses. Optional macro VGA_FRAME_COUNT_EN adds
//            a 16-bit frame counter output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_ce,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       sync,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL or V_TOTAL exceeds 1024");
    end
  endgenerate

  localparam logic [9:0]  C_H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  C_V_LAST   = 10'(V_TOTAL - 1);
  // 11-bit bounds so an end value of exactly 1024 still compares correctly
  localparam logic [10:0] C_H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] C_V_VIS    = 11'(V_VISIBLE);
  localparam logic [10:0] C_HS_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] C_HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] C_VS_START = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] C_VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       blank_q, blank_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [10:0] hx_ext;
  logic [10:0] vy_ext;

  always_comb begin
    hc_d          = hc_q;
    vc_d          = vc_q;
    hs_d          = hs_q;
    vs_d          = vs_q;
    blank_d       = blank_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    hx_ext        = 11'd0;
    vy_ext        = 11'd0;
    if (pix_ce) begin
      if (hc_q == C_H_LAST) begin
        hc_d = 10'd0;
        vc_d = (vc_q == C_V_LAST) ? 10'd0 : vc_q + 10'd1;
      end else begin
        hc_d = hc_q + 10'd1;
      end
      // Decode from next-state counters so strobes line up with DrawX/DrawY
      hx_ext        = {1'b0, hc_d};
      vy_ext        = {1'b0, vc_d};
      hs_d          = !((hx_ext >= C_HS_START) && (hx_ext < C_HS_END));
      vs_d          = !((vy_ext >= C_VS_START) && (vy_ext < C_VS_END));
      blank_d       = (hx_ext < C_H_VIS) && (vy_ext < C_V_VIS);
      line_start_d  = (hc_d == 10'd0);
      frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign sync        = 1'b0;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (pix_ce && (hc_q == C_H_LAST) && (vc_q == C_V_LAST)) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Desc     : Self-checking bench for vga_timing_gen using a reduced raster.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  localparam int HV = 16, HF = 4, HSY = 6, HB = 6;
  localparam int VV = 12, VF = 2, VSY = 2, VB = 4;
  localparam int HT = HV + HF + HSY + HB;   // 32
  localparam int VT = VV + VF + VSY + VB;   // 20

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pix_ce  = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       hs, vs, blank, sync, line_start, frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .pix_ce     (pix_ce),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .hs         (hs),
    .vs         (vs),
    .blank      (blank),
    .sync       (sync),
    .line_start (line_start),
    .frame_start(frame_start)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int x, y, hs, vs, blank, ls, fs, fc;
  } exp_t;

  typedef struct {
    int adv, x, y, hs, vs, blank;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   adv    = 0;
  exp_t sb_q[$];
  vec_t tbl[16];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference raster derived from the total count of advancing edges
  function automatic exp_t model(input int a, input bit adv_edge);
    exp_t e;
    int   h, v;
    h       = a % HT;
    v       = (a / HT) % VT;
    e.x     = h;
    e.y     = v;
    e.hs    = (h >= HV + HF && h < HV + HF + HSY) ? 0 : 1;
    e.vs    = (v >= VV + VF && v < VV + VF + VSY) ? 0 : 1;
    e.blank = (a != 0 && h < HV && v < VV) ? 1 : 0;
    e.ls    = (adv_edge && h == 0) ? 1 : 0;
    e.fs    = (adv_edge && h == 0 && v == 0) ? 1 : 0;
    e.fc    = (a / (HT * VT)) % 65536;
    return e;
  endfunction

  task automatic step(input logic ce);
    exp_t e, g;
    @(negedge vga_clk);
    pix_ce = ce;
    if (!reset_n) adv = 0;
    else if (ce) adv++;
    e = model(adv, reset_n && ce);
    sb_q.push_back(e);
    @(posedge vga_clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      g = sb_q.pop_front();
      chk("DrawX", int'(DrawX), g.x);
      chk("DrawY", int'(DrawY), g.y);
      chk("hs", int'(hs), g.hs);
      chk("vs", int'(vs), g.vs);
      chk("blank", int'(blank), g.blank);
      chk("line_start", int'(line_start), g.ls);
      chk("frame_start", int'(frame_start), g.fs);
      chk("sync", int'(sync), 0);
`ifdef VGA_FRAME_COUNT_EN
      chk("frame_count", int'(frame_count), g.fc);
`endif
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_DrawX"}, int'(DrawX), 0);
    chk({tag, "_DrawY"}, int'(DrawY), 0);
    chk({tag, "_hs"}, int'(hs), 1);
    chk({tag, "_vs"}, int'(vs), 1);
    chk({tag, "_blank"}, int'(blank), 0);
    chk({tag, "_line_start"}, int'(line_start), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Hand-computed raster points: {edges since reset, x, y, hs, vs, blank}
    tbl[0]  = '{0,   0,  0,  1, 1, 0};
    tbl[1]  = '{1,   1,  0,  1, 1, 1};
    tbl[2]  = '{15,  15, 0,  1, 1, 1};
    tbl[3]  = '{16,  16, 0,  1, 1, 0};
    tbl[4]  = '{20,  20, 0,  0, 1, 0};
    tbl[5]  = '{25,  25, 0,  0, 1, 0};
    tbl[6]  = '{26,  26, 0,  1, 1, 0};
    tbl[7]  = '{31,  31, 0,  1, 1, 0};
    tbl[8]  = '{32,  0,  1,  1, 1, 1};
    tbl[9]  = '{383, 31, 11, 1, 1, 0};
    tbl[10] = '{384, 0,  12, 1, 1, 0};
    tbl[11] = '{448, 0,  14, 1, 0, 0};
    tbl[12] = '{470, 22, 14, 0, 0, 0};
    tbl[13] = '{512, 0,  16, 1, 1, 0};
    tbl[14] = '{640, 0,  0,  1, 1, 1};
    tbl[15] = '{641, 1,  0,  1, 1, 1};

    // Reset held with pix_ce high: nothing moves
    repeat (2) @(negedge vga_clk);
    chk_reset_state("reset");
    step(1'b1);
    step(1'b1);

    // Release with pix_ce low: blank must stay 0 until an advancing edge
    @(negedge vga_clk);
    reset_n = 1'b1;
    pix_ce  = 1'b0;
    step(1'b0);

    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < 1000 && adv < tbl[i].adv; n++) step(1'b1);
      chk($sformatf("tbl%0d_DrawX", i), int'(DrawX), tbl[i].x);
      chk($sformatf("tbl%0d_DrawY", i), int'(DrawY), tbl[i].y);
      chk($sformatf("tbl%0d_hs", i), int'(hs), tbl[i].hs);
      chk($sformatf("tbl%0d_vs", i), int'(vs), tbl[i].vs);
      chk($sformatf("tbl%0d_blank", i), int'(blank), tbl[i].blank);
    end

    // Half-rate pixel enable across more than a full frame
    for (int i = 0; i < 1400; i++) step((i % 2) == 0);

    // Random pixel enable
    for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 1)));

    // Mid-frame asynchronous reset at (10,5)
    for (int n = 0; n < 700 && (adv % (HT * VT)) != (5 * HT + 10); n++) step(1'b1);
    chk("midframe_DrawX", int'(DrawX), 10);
    chk("midframe_DrawY", int'(DrawY), 5);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    step(1'b1);
    step(1'b1);
    @(negedge vga_clk);
    reset_n = 1'b1;
    pix_ce  = 1'b0;
    step(1'b1);
    chk("release_DrawX", int'(DrawX), 1);
    chk("release_blank", int'(blank), 1);
    for (int i = 0; i < 2 * HT * VT + 5; i++) step(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
